ccg_sweep_signature: RTL and testbench
======================================

# ccg_sweep_signature

Parametrised exhaustive-sweep signature engine for generated combinational benchmarks. It drives every input vector 0..2^N_IN−1 into an external circuit under test (CUT) and compresses the CUT outputs into a MISR signature. It also reports which outputs toggled at least once during the sweep. It sits beside each benchmark netlist so original and resynthesised variants can be compared for equivalence on silicon or in simulation.

## Interface
- N_IN, 12: CUT input count; sweep length 2^N_IN.
- N_OUT, 18: CUT output count.
- SIG_W, 32: signature width.
- POLY, 32'h04C1_1DB7: MISR feedback polynomial; the low SIG_W bits are used.
- SEED, 0: signature value loaded on start.
- CUT_LAT, 0: CUT pipeline latency in cycles, 0..15.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  cancel an active sweep.
- cut_in  out  N_IN  vector driven to the CUT.
- cut_out  in  N_OUT  CUT response.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  one-cycle pulse in the DONE state.
- result_valid  out  1  high from DONE until the next accepted start, abort or reset.
- signature  out  SIG_W  MISR state.
- toggle_mask  out  N_OUT  bit i set if cut_out[i] was sampled as both 0 and 1.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE → SWEEP on start. On the same edge:
  - signature ← SEED; vector counter ← 0;
  - toggle_mask and seen-0/seen-1 trackers cleared;
  - result_valid ← 0.
- SWEEP:
  - cut_in equals the counter; counter increments each cycle.
  - After the cycle presenting 2^N_IN−1: go to DRAIN if CUT_LAT>0, else DONE.
  - The counter is N_IN+1 bits wide so the terminal vector is detected without relying on wrap-around.
- DRAIN: lasts exactly CUT_LAT cycles; cut_in holds the last vector; then DONE.
- DONE: done=1, result_valid ← 1, then IDLE.
- Sampling:
  - A valid flag tags each driven vector and is delayed CUT_LAT stages.
  - cut_out is absorbed only when the delayed flag is set, so each vector is absorbed exactly once.
- MISR update: sig ← (sig<<1) ^ (sig[SIG_W−1] ? POLY : 0) ^ fold(cut_out).
  - fold zero-extends cut_out when N_OUT ≤ SIG_W.
  - Otherwise fold XORs successive SIG_W-bit chunks, zero-padding the last chunk.
- toggle_mask[i] = seen0[i] & seen1[i], updated on every absorbed sample.
- abort in SWEEP or DRAIN:
  - IDLE on the next edge; no done pulse; result_valid stays 0.
  - signature and toggle_mask hold their partial values.
  - The valid pipe is flushed.
- abort in IDLE or DONE is ignored.
- start while busy is ignored.
- start and abort together in IDLE: start wins.

## Timing
- Reset values:
  - state IDLE; cut_in 0; busy 0; done 0; result_valid 0; signature 0; toggle_mask 0.
  - Valid pipe cleared.
- Reset asserted mid-sweep returns everything to these values immediately; no done pulse.
- start sampled high at edge E:
  - busy and cut_in=0 from E.
  - Vector k is on cut_in for cycle k after E.
  - Vector k is sampled at edge E+k+1+CUT_LAT.
- done is high for the single cycle following edge E+2^N_IN+CUT_LAT.
  - signature and toggle_mask are final in that cycle and hold until the next start.
- busy falls on the same edge that raises done.
- No combinational path from any input to any output.

## Structure
- Package ccg_sweep_pkg:
  - state enum;
  - default POLY constant;
  - fold function, parametrised on N_OUT and SIG_W.
- Sub-module ccg_misr (parameters SIG_W, N_OUT, POLY):
  - inputs: load, seed, en, data;
  - output: sig.
- The top level holds the FSM, counter, valid delay line and toggle trackers.

## Test plan
- N_IN=2, N_OUT=1, SIG_W=8, POLY=8'h1D, SEED=0, CUT_LAT=0, cut_out=cut_in[0]:
  - start → cut_in 0,1,2,3 on consecutive cycles;
  - done exactly 5 cycles after start edge;
  - signature=8'h05, toggle_mask=1'b1.
- Same setup with CUT_LAT=3 (CUT delayed by 3 registers):
  - signature=8'h05 again;
  - done 8 cycles after start edge;
  - busy high for 7 cycles.
- N_OUT=2, cut_out={1'b0, cut_in[1]}: toggle_mask=2'b01. Then rerun with cut_out[1] tied 1: toggle_mask=2'b01 again, with a different signature.
- N_IN=12, N_OUT=18 with two functions fanned out as f1/f8-style replicas, run twice (original vs resynthesised model): signatures match and done arrives at cycle 4097. Flipping one minterm of one replica changes the signature.
- abort at SWEEP cycle 1 of a 4-vector run:
  - busy drops next edge; no done; result_valid=0;
  - the next start yields 8'h05.
- rst_n pulsed low mid-DRAIN: all outputs are 0 immediately; no done; a subsequent sweep is correct.

Source files
------------

// File: rtl/ccg_sweep_signature_pkg.sv
// ccg_sweep_signature shared types and helpers.
// State encoding, default polynomial and output folding.
package ccg_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;

  localparam int FOLD_MAX_IN  = 256;
  localparam int FOLD_MAX_SIG = 64;

  // Fold n_out data bits onto sig_w bits: bit i lands on
  // position i mod sig_w, so narrow outputs are zero-extended
  // and wide outputs XOR successive chunks (last one padded).
  function automatic logic [FOLD_MAX_SIG-1:0] fold(
    input logic [FOLD_MAX_IN-1:0] data,
    input int                     n_out,
    input int                     sig_w
  );
    logic [FOLD_MAX_SIG-1:0] r;
    int                      j;
    r = '0;
    for (int i = 0; i < FOLD_MAX_IN; i++) begin
      if (i < n_out) begin
        j = i % sig_w;
        r[j[5:0]] = r[j[5:0]] ^ data[i[7:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ccg_sweep_signature_if.sv
// ccg_sweep_signature control, CUT and result bundle.
// master = engine side, slave = environment side.
interface ccg_sweep_signature_if #(
  parameter int N_IN  = 12,
  parameter int N_OUT = 18,
  parameter int SIG_W = 32
);

  logic             start;
  logic             abort;
  logic [N_IN-1:0]  cut_in;
  logic [N_OUT-1:0] cut_out;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic [SIG_W-1:0] signature;
  logic [N_OUT-1:0] toggle_mask;

  modport master (
    input  start,
    input  abort,
    input  cut_out,
    output cut_in,
    output busy,
    output done,
    output result_valid,
    output signature,
    output toggle_mask
  );

  modport slave (
    output start,
    output abort,
    output cut_out,
    input  cut_in,
    input  busy,
    input  done,
    input  result_valid,
    input  signature,
    input  toggle_mask
  );

endinterface

// File: rtl/ccg_sweep_signature_misr.sv
// ccg_misr: multiple-input signature register.
// Seed load wins over absorb; output folded onto SIG_W bits.
module ccg_misr
  import ccg_sweep_pkg::*;
#(
  parameter int               SIG_W = 32,
  parameter int               N_OUT = 18,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic [N_OUT-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] fold_w;
  logic [SIG_W-1:0] fb_w;

  // Next signature: seed on load, shift/feedback/xor on absorb.
  always_comb begin
    fold_w = SIG_W'(fold(FOLD_MAX_IN'(data), N_OUT, SIG_W));
    fb_w   = sig_q[SIG_W-1] ? POLY : '0;
    sig_d  = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ fb_w ^ fold_w;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/ccg_sweep_signature.sv
// ccg_sweep_signature: exhaustive CUT sweep with MISR.
// Sweep FSM, vector counter, valid delay line, toggles.
module ccg_sweep_signature
  import ccg_sweep_pkg::*;
#(
  parameter int               N_IN    = 12,
  parameter int               N_OUT   = 18,
  parameter int               SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED    = '0,
  parameter int               CUT_LAT = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  ccg_sweep_signature_if.master bus
);

  state_e           state_q;
  state_e           state_d;
  logic [N_IN:0]    cnt_q;
  logic [N_IN:0]    cnt_d;
  logic [N_IN-1:0]  cut_in_q;
  logic [N_IN-1:0]  cut_in_d;
  logic [3:0]       dr_q;
  logic [3:0]       dr_d;
  logic             rv_q;
  logic             rv_d;
  logic [N_OUT-1:0] seen0_q;
  logic [N_OUT-1:0] seen0_d;
  logic [N_OUT-1:0] seen1_q;
  logic [N_OUT-1:0] seen1_d;
  logic             load;
  logic             abort_hit;
  logic             vld_in;
  logic             absorb;

  assign vld_in = (state_q == ST_SWEEP);

  // Next state, counter, drain timer and result flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cut_in_d  = cut_in_q;
    dr_d      = dr_q;
    rv_d      = rv_q;
    load      = 1'b0;
    abort_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SWEEP;
          cnt_d    = '0;
          cut_in_d = '0;
          rv_d     = 1'b0;
          load     = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          abort_hit = 1'b1;
          rv_d      = 1'b0;
        end else begin
          cnt_d = cnt_q + (N_IN+1)'(1);
          if (cnt_d[N_IN]) begin
            if (CUT_LAT > 0) begin
              state_d = ST_DRAIN;
              dr_d    = 4'(CUT_LAT - 1);
            end else begin
              state_d = ST_DONE;
              rv_d    = 1'b1;
            end
          end else begin
            cut_in_d = cnt_d[N_IN-1:0];
          end
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          abort_hit = 1'b1;
          rv_d      = 1'b0;
        end else if (dr_q == 4'd0) begin
          state_d = ST_DONE;
          rv_d    = 1'b1;
        end else begin
          dr_d = dr_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Seen-0 / seen-1 trackers, cleared on an accepted start.
  always_comb begin
    seen0_d = seen0_q;
    seen1_d = seen1_q;
    if (load) begin
      seen0_d = '0;
      seen1_d = '0;
    end else if (absorb) begin
      seen0_d = seen0_q | ~bus.cut_out;
      seen1_d = seen1_q | bus.cut_out;
    end
  end

  // Control and tracker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cut_in_q <= '0;
      dr_q     <= '0;
      rv_q     <= 1'b0;
      seen0_q  <= '0;
      seen1_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cut_in_q <= cut_in_d;
      dr_q     <= dr_d;
      rv_q     <= rv_d;
      seen0_q  <= seen0_d;
      seen1_q  <= seen1_d;
    end
  end

  if (CUT_LAT == 0) begin : g_nolat
    assign absorb = vld_in;
  end else begin : g_lat
    logic [CUT_LAT-1:0] vp_q;
    logic [CUT_LAT-1:0] vp_d;

    // Valid tag follows each vector through the CUT latency.
    always_comb begin
      vp_d    = vp_q << 1;
      vp_d[0] = vld_in;
      if (abort_hit) begin
        vp_d = '0;
      end
    end

    // Valid delay line register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vp_q <= '0;
      end else begin
        vp_q <= vp_d;
      end
    end

    assign absorb = vp_q[CUT_LAT-1];
  end

  ccg_misr #(
    .SIG_W (SIG_W),
    .N_OUT (N_OUT),
    .POLY  (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .seed  (SEED),
    .en    (absorb),
    .data  (bus.cut_out),
    .sig   (bus.signature)
  );

  assign bus.cut_in       = cut_in_q;
  assign bus.busy         = (state_q == ST_SWEEP) ||
                            (state_q == ST_DRAIN);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.result_valid = rv_q;
  assign bus.toggle_mask  = seen0_q & seen1_q;

endmodule

// File: tb/tb_ccg_sweep_signature.sv
// Bench for ccg_sweep_signature: four configured engines,
// random CUT tables, behavioural signature/toggle model.
module tb_ccg_sweep_signature;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start_v [4];
  logic        abort_v [4];
  logic [11:0] cut_in_v [4];
  logic        busy_v [4];
  logic        done_v [4];
  logic        rv_v [4];
  logic [31:0] sig_v [4];
  logic [31:0] tm_v [4];

  logic        c_hi = 1'b0;
  int          variant = 0;
  int          flip_m = 0;
  bit          t1 [4096];
  bit          t1n [4096];
  bit          t2 [4096];

  ccg_sweep_signature_if #(.N_IN(2), .N_OUT(1), .SIG_W(8)) ifa ();
  ccg_sweep_signature_if #(.N_IN(2), .N_OUT(1), .SIG_W(8)) ifb ();
  ccg_sweep_signature_if #(.N_IN(2), .N_OUT(2), .SIG_W(8)) ifc ();
  ccg_sweep_signature_if #(.N_IN(12), .N_OUT(18), .SIG_W(32)) ifd ();

  ccg_sweep_signature #(
    .N_IN(2), .N_OUT(1), .SIG_W(8), .POLY(8'h1D),
    .SEED(8'h00), .CUT_LAT(0)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  ccg_sweep_signature #(
    .N_IN(2), .N_OUT(1), .SIG_W(8), .POLY(8'h1D),
    .SEED(8'h00), .CUT_LAT(3)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  ccg_sweep_signature #(
    .N_IN(2), .N_OUT(2), .SIG_W(8), .POLY(8'h1D),
    .SEED(8'h00), .CUT_LAT(0)
  ) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  ccg_sweep_signature #(
    .N_IN(12), .N_OUT(18), .SIG_W(32),
    .POLY(32'h04C1_1DB7), .SEED(32'h0), .CUT_LAT(0)
  ) u_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

  // CUT models
  assign ifa.cut_out = ifa.cut_in[0];

  logic [2:0] bd = '0;
  always_ff @(posedge clk) bd <= {bd[1:0], ifb.cut_in[0]};
  assign ifb.cut_out = bd[2];

  assign ifc.cut_out = {c_hi, ifc.cut_in[1]};

  logic f1d;
  logic f2d;
  assign f1d = (variant == 1) ? ~t1n[ifd.cut_in]
             : (t1[ifd.cut_in] ^ ((variant == 2) &&
                (32'(ifd.cut_in) == flip_m)));
  assign f2d = t2[ifd.cut_in];
  assign ifd.cut_out = {9{f2d, f1d}};

  assign ifa.start = start_v[0];
  assign ifb.start = start_v[1];
  assign ifc.start = start_v[2];
  assign ifd.start = start_v[3];
  assign ifa.abort = abort_v[0];
  assign ifb.abort = abort_v[1];
  assign ifc.abort = abort_v[2];
  assign ifd.abort = abort_v[3];

  assign cut_in_v[0] = 12'(ifa.cut_in);
  assign cut_in_v[1] = 12'(ifb.cut_in);
  assign cut_in_v[2] = 12'(ifc.cut_in);
  assign cut_in_v[3] = ifd.cut_in;
  assign busy_v[0] = ifa.busy;
  assign busy_v[1] = ifb.busy;
  assign busy_v[2] = ifc.busy;
  assign busy_v[3] = ifd.busy;
  assign done_v[0] = ifa.done;
  assign done_v[1] = ifb.done;
  assign done_v[2] = ifc.done;
  assign done_v[3] = ifd.done;
  assign rv_v[0] = ifa.result_valid;
  assign rv_v[1] = ifb.result_valid;
  assign rv_v[2] = ifc.result_valid;
  assign rv_v[3] = ifd.result_valid;
  assign sig_v[0] = 32'(ifa.signature);
  assign sig_v[1] = 32'(ifb.signature);
  assign sig_v[2] = 32'(ifc.signature);
  assign sig_v[3] = ifd.signature;
  assign tm_v[0] = 32'(ifa.toggle_mask);
  assign tm_v[1] = 32'(ifb.toggle_mask);
  assign tm_v[2] = 32'(ifc.toggle_mask);
  assign tm_v[3] = 32'(ifd.toggle_mask);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp_v);
    end
  endtask

  // What the CUT of engine d answers for vector v.
  function automatic logic [31:0] cut_word(int d, int v);
    logic [31:0] w;
    logic        f1;
    logic        f2;
    w = '0;
    case (d)
      0, 1: w = 32'(v & 1);
      2: w = {30'd0, c_hi, v[1]};
      default: begin
        f1 = t1[v] ^ ((variant == 2) && (v == flip_m));
        f2 = t2[v];
        for (int r = 0; r < 9; r++) begin
          w[2*r]   = f1;
          w[2*r+1] = f2;
        end
      end
    endcase
    return w;
  endfunction

  // Signature and toggle mask after absorbing every vector.
  task automatic model(input int d, input int nvec,
                       input int sig_w, input int n_out,
                       input logic [31:0] poly,
                       output logic [31:0] e_sig,
                       output logic [31:0] e_tm);
    longint unsigned s;
    longint unsigned mask;
    longint unsigned msb;
    logic [31:0]     w;
    logic [31:0]     om;
    logic [31:0]     z;
    logic [31:0]     o;
    s = 0;
    mask = (64'd1 << sig_w) - 1;
    om = 32'((64'd1 << n_out) - 1);
    z = '0;
    o = '0;
    for (int v = 0; v < nvec; v++) begin
      w = cut_word(d, v);
      msb = (s >> (sig_w - 1)) & 1;
      s = ((s << 1) ^ (msb != 0 ? 64'(poly) : 64'd0)
           ^ 64'(w)) & mask;
      o = o | w;
      z = z | (~w & om);
    end
    e_sig = s[31:0];
    e_tm = z & o;
  endtask

  // One full sweep with timing, sequence and result checks.
  task automatic sweep(input int d, input int nvec,
                       input int lat, input int sig_w,
                       input int n_out, input logic [31:0] poly,
                       output logic [31:0] got);
    int done_k;
    int done_n;
    int busy_n;
    int seq_err;
    logic [31:0] e_sig;
    logic [31:0] e_tm;
    done_k = -1;
    done_n = 0;
    busy_n = 0;
    seq_err = 0;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    chk($sformatf("d%0d_busy_k0", d), 32'(busy_v[d]), 32'd1);
    for (int k = 0; k < nvec + lat + 4; k++) begin
      if (k > 0) @(negedge clk);
      if (done_v[d]) begin
        if (done_k < 0) done_k = k;
        done_n++;
      end
      if (busy_v[d]) busy_n++;
      if (k < nvec) begin
        if (32'(cut_in_v[d]) != k) seq_err++;
      end else if (k < nvec + lat) begin
        if (32'(cut_in_v[d]) != nvec - 1) seq_err++;
      end
    end
    model(d, nvec, sig_w, n_out, poly, e_sig, e_tm);
    chk($sformatf("d%0d_done_at", d), done_k, nvec + lat);
    chk($sformatf("d%0d_done_n", d), done_n, 1);
    chk($sformatf("d%0d_busy_n", d), busy_n, nvec + lat);
    chk($sformatf("d%0d_seq", d), seq_err, 0);
    chk($sformatf("d%0d_rv", d), 32'(rv_v[d]), 32'd1);
    chk($sformatf("d%0d_sig", d), sig_v[d], e_sig);
    chk($sformatf("d%0d_tm", d), tm_v[d], e_tm);
    got = sig_v[d];
  endtask

  logic [31:0] s0;
  logic [31:0] s1;
  logic [31:0] s2;
  int          dn;

  initial begin
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    for (int i = 0; i < 4096; i++) begin
      t1[i] = bit'($urandom_range(0, 1));
      t1n[i] = ~t1[i];
      t2[i] = bit'($urandom_range(0, 1));
    end
    flip_m = int'($urandom_range(0, 4095));
    repeat (3) @(negedge clk);

    chk("rst_cut_in", 32'(cut_in_v[3]), 32'd0);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_done", 32'(done_v[0]), 32'd0);
    chk("rst_rv", 32'(rv_v[0]), 32'd0);
    chk("rst_sig", sig_v[3], 32'd0);
    chk("rst_tm", tm_v[3], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 4-vector sweep, no latency
    sweep(0, 4, 0, 8, 1, 32'h1D, s0);
    chk("a_sig_const", s0, 32'h05);
    chk("a_tm_const", tm_v[0], 32'h1);

    // Same function through a 3-stage CUT
    sweep(1, 4, 3, 8, 1, 32'h1D, s0);
    chk("b_sig_const", s0, 32'h05);

    // Two outputs, high one constant 0 then constant 1
    c_hi = 1'b0;
    sweep(2, 4, 0, 8, 2, 32'h1D, s0);
    chk("c0_tm_const", tm_v[2], 32'h1);
    c_hi = 1'b1;
    sweep(2, 4, 0, 8, 2, 32'h1D, s1);
    chk("c1_tm_const", tm_v[2], 32'h1);
    chk("c_sig_differs", 32'(s0 != s1), 32'd1);

    // Abort in sweep cycle 1
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      if (done_v[0]) dn++;
      @(negedge clk);
    end
    chk("abort_no_done", dn, 0);
    chk("abort_rv", 32'(rv_v[0]), 32'd0);
    sweep(0, 4, 0, 8, 1, 32'h1D, s0);
    chk("abort_rerun_sig", s0, 32'h05);

    // Reset pulse while draining
    @(negedge clk);
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("drain_busy_pre", 32'(busy_v[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_cut_in", 32'(cut_in_v[1]), 32'd0);
    chk("mrst_busy", 32'(busy_v[1]), 32'd0);
    chk("mrst_done", 32'(done_v[1]), 32'd0);
    chk("mrst_rv", 32'(rv_v[1]), 32'd0);
    chk("mrst_sig", sig_v[1], 32'd0);
    chk("mrst_tm", tm_v[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_v[1]) dn++;
    end
    chk("mrst_no_done", dn, 0);
    sweep(1, 4, 3, 8, 1, 32'h1D, s0);
    chk("mrst_rerun_sig", s0, 32'h05);

    // Full 12-input sweep: original, resynthesised, mutant
    variant = 0;
    sweep(3, 4096, 0, 32, 18, 32'h04C1_1DB7, s0);
    variant = 1;
    sweep(3, 4096, 0, 32, 18, 32'h04C1_1DB7, s1);
    chk("d_equiv", s1, s0);
    variant = 2;
    sweep(3, 4096, 0, 32, 18, 32'h04C1_1DB7, s2);
    chk("d_mutant_differs", 32'(s2 != s0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
